// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one single-port synchronous ROM between requesters A and B.
// Latency: a request seen in IDLE is acked 2+LAT cycles later; back-to-back transfers run every 3+LAT cycles.
// Backpressure: requests are level-held, so a port waiting behind the other stays pending until its grant.
module rom_arbiter #(
    parameter int DW  = 8,
    parameter int AW  = 14,
    parameter int LAT = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_ack,
    output logic [DW-1:0] a_data,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_ack,
    output logic [DW-1:0] b_data,
    output logic          rom_ce,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [1:0] LAT_M1 = 2'(LAT - 1);

    state_t        state, state_nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic          grant_b, grant_b_nxt;   // port holding the ROM: 0 = A, 1 = B
    logic          last_b, last_b_nxt;
    logic          a_ack_nxt, b_ack_nxt, rom_ce_nxt;
    logic [AW-1:0] rom_addr_nxt;
    logic [DW-1:0] a_data_nxt, b_data_nxt;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        grant_b_nxt  = grant_b;
        last_b_nxt   = last_b;
        a_ack_nxt    = 1'b0;
        b_ack_nxt    = 1'b0;
        rom_ce_nxt   = 1'b0;
        rom_addr_nxt = rom_addr;
        a_data_nxt   = a_data;
        b_data_nxt   = b_data;
        unique case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    // on a tie the port that did not win last time goes next
                    grant_b_nxt  = b_req && (!a_req || !last_b);
                    last_b_nxt   = grant_b_nxt;
                    rom_addr_nxt = grant_b_nxt ? b_addr : a_addr;
                    rom_ce_nxt   = 1'b1;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = LAT_M1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt != 2'd0) begin
                    cnt_nxt = cnt - 2'd1;
                end else begin
                    if (grant_b) begin
                        b_data_nxt = rom_data;
                        b_ack_nxt  = 1'b1;
                    end else begin
                        a_data_nxt = rom_data;
                        a_ack_nxt  = 1'b1;
                    end
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            grant_b  <= 1'b0;
            last_b   <= 1'b1;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            rom_ce   <= 1'b0;
            rom_addr <= '0;
            a_data   <= '0;
            b_data   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            grant_b  <= grant_b_nxt;
            last_b   <= last_b_nxt;
            a_ack    <= a_ack_nxt;
            b_ack    <= b_ack_nxt;
            rom_ce   <= rom_ce_nxt;
            rom_addr <= rom_addr_nxt;
            a_data   <= a_data_nxt;
            b_data   <= b_data_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Two-requester controller for one single-port synchronous ROM with a fixed read latency.
- Accepts level-held read requests from port A and port B. Picks a winner by round-robin and drives the ROM address and chip enable.
- Captures the ROM word after LAT cycles and returns it with a one-cycle ack pulse.
- Sits between the ROM instance and its consumers (e.g. BIOS fetch and a DMA/shadow copier) so both can share one ROM.

Parameters:
- DW, 8, ROM data width.
- AW, 14, ROM address width.
- LAT, 1, ROM read latency in clocks from the ROM address-sample edge to valid rom_data; legal range 1..4.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous reset, active-low.
- a_req  input  1  port A read request; level, held until a_ack.
- a_addr  input  AW  port A address; stable while a_req is high.
- a_ack  output  1  one-cycle pulse; a_data is valid from this cycle.
- a_data  output  DW  last word read for A; held until the next A ack.
- b_req  input  1  port B request; same rules as A.
- b_addr  input  AW  port B address.
- b_ack  output  1  port B ack pulse.
- b_data  output  DW  port B read data, held.
- rom_ce  output  1  ROM enable; high only in the ISSUE cycle.
- rom_addr  output  AW  registered ROM address.
- rom_data  input  DW  ROM read data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE, a_ack=b_ack=0, a_data=b_data=0, rom_ce=0, rom_addr=0, wait counter=0, last_grant=B.
  - Any transfer in flight is abandoned; no ack is ever issued for it.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If only one request is pending, grant it.
  - If both are pending, grant the port not equal to last_grant.
  - On grant: latch grant, set rom_addr <= granted addr, rom_ce <= 1, last_grant <= granted, go to ISSUE.
- ISSUE (1 cycle):
  - rom_ce=1 and rom_addr valid; the ROM samples the address at the end of this cycle.
  - rom_ce <= 0, counter <= LAT-1, go to WAIT.
- WAIT:
  - If counter!=0, decrement and stay.
  - If counter==0, rom_data is valid this cycle: capture it into the granted port's data register, set that port's ack <= 1, go to ACK.
- ACK (1 cycle):
  - Granted ack=1 and data valid. Clear ack next cycle and go to IDLE. No arbitration happens in ACK.
- Latency:
  - Request sampled in IDLE at cycle 0 → ack at cycle 2+LAT (cycle 3 for LAT=1).
  - Back-to-back service period is 3+LAT cycles.
- Requester rule:
  - Deassert req in the cycle after ack.
  - A req still high when the arbiter returns to IDLE is treated as a new request.
- Other ports:
  - Requests arriving while busy are held pending; they are not lost because they are level-held.
  - The data register of the non-granted port never changes.
  - The ack signals are never both high.
  - rom_addr holds its value after ISSUE until the next grant.
- Arbitration fairness:
  - With both requesters continuously requesting, grants strictly alternate A,B,A,B…
  - After reset, A wins the first tie.

Test Plan:
- ROM image d[i]=i[7:0]^8'h5A, LAT=1. Hold a_req with a_addr=14'h0010 → rom_ce high exactly one cycle with rom_addr=0x0010; a_ack pulses at cycle 3; a_data=8'h4A and is held after a_req drops; b_ack stays 0.
- Raise a_req (addr 0x0001) and b_req (addr 0x0002) together right after reset → A served first (a_data=8'h5B); B's ack follows 4 cycles later (b_data=8'h58).
- Hold both requests continuously for 6 transactions → ack order A,B,A,B,A,B; ack spacing 4 cycles; never two acks in the same cycle.
- Raise b_req (addr 0x3FFF) while A is in WAIT → B is not granted until IDLE; b_ack arrives and b_data=8'hA5. Top-address boundary passes.
- Pull reset_n low during WAIT → the next cycle shows busy=0, rom_ce=0, no ack; a_data=0. A request re-raised after reset completes normally.
- Set LAT=3 with a_addr=0x00FF → a_ack at cycle 5; a_data=8'hA5; busy high for cycles 1-5.
